md5_guess_generator: RTL and testbench
======================================

MD5_GUESS_GENERATOR -- requirements
Module: md5_guess_generator

Interface
REQ-001 Parameter: MAX_LEN, 15, largest guess length in bytes; SHALL be 1..15, matching the 4-bit guesslen of the hash pipeline.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  single-cycle pulse that begins an enumeration.
REQ-005 start_len  input  4  first guess length in bytes.
REQ-006 end_len  input  4  last guess length in bytes, inclusive.
REQ-007 char_lo  input  8  lowest charset byte, inclusive.
REQ-008 char_hi  input  8  highest charset byte, inclusive.
REQ-009 stall  input  1  hold request from the consumer.
REQ-010 guess  output  128  current guess; character position i (0 = first) SHALL be at guess[127-8i -: 8]; bytes at positions >= guesslen SHALL be 0x00.
REQ-011 guesslen  output  4  length of the current guess.
REQ-012 guess_valid  output  1  guess and guesslen are a new, enumerated candidate.
REQ-013 busy  output  1  high while in RUN.
REQ-014 done  output  1  enumeration finished; a level that stays high until the next accepted start.
REQ-015 cfg_err  output  1  last start had an illegal configuration.
REQ-016 guess_count  output  48  number of guesses consumed since the last accepted start.

Function
REQ-017 The block SHALL have the states IDLE, RUN and DONE.
REQ-018 start SHALL be accepted in IDLE or DONE.
- start SHALL be ignored in RUN.
REQ-019 On an accepted start, the block SHALL latch start_len, end_len, char_lo and char_hi, and clear guess_count, done and cfg_err.
- Later changes to these inputs SHALL have no effect until the next accepted start.
REQ-020 The configuration is illegal if start_len==0, end_len>MAX_LEN, start_len>end_len, or char_lo>char_hi.
- On an illegal start, the next cycle SHALL be DONE with cfg_err=1, done=1, and guess_valid never asserted.
REQ-021 On a legal start, the next cycle SHALL be RUN with:
- guess_valid=1, guesslen=start_len;
- every active byte equal to char_lo; all other bytes 0x00.
REQ-022 In RUN, a guess is consumed on a cycle where guess_valid=1 and stall=0.
- On consumption, guess_count SHALL increment by 1 (wrapping modulo 2^48).
- On consumption, the next guess SHALL be presented on the following cycle.
REQ-023 In RUN with stall=1, guess, guesslen, guess_valid and guess_count SHALL hold unchanged.
REQ-024 Next guess (odometer order), rightmost position first:
- The byte at position guesslen-1 increments.
- A byte equal to char_hi wraps to char_lo and carries into the position to its left.
REQ-025 When the carry leaves position 0, guesslen SHALL increment by 1 and all positions 0..new guesslen-1 SHALL be char_lo.
REQ-026 When the guess of length end_len with every byte char_hi is consumed:
- the next cycle SHALL be DONE with guess_valid=0, busy=0, done=1;
- guess and guesslen SHALL hold the last value.
REQ-027 Total guesses per run SHALL be the sum over L = start_len..end_len of (char_hi-char_lo+1)^L.
REQ-028 char_lo==char_hi SHALL be legal: exactly one guess per length.
REQ-029 char_hi=0xFF SHALL wrap to char_lo with no 8-bit overflow artefact.
REQ-030 Outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-031 While reset=1, the block SHALL force IDLE with:
- guess=0, guesslen=0, guess_valid=0, busy=0, done=0, cfg_err=0, guess_count=0.
REQ-032 Reset asserted mid-RUN SHALL abort the enumeration immediately; no further guess_valid until a new accepted start after reset deasserts.
REQ-033 A start coincident with reset SHALL be ignored.

Verification
REQ-034 char_lo=0x61, char_hi=0x63, start_len=end_len=1, stall=0 -> three consecutive valid cycles with guess[127:120]=0x61, 0x62, 0x63, guesslen=1; then done=1, guess_count=3.
REQ-035 char_lo=0x61, char_hi=0x62, start_len=1, end_len=2 -> guess order a, b, aa, ab, ba, bb.
- "aa" SHALL appear as guess[127:112]=0x6161 with guess[111:0]=0 and guesslen=2.
- guess_count=6 at done.
REQ-036 stall held for 3 cycles while guess="ab" -> guess unchanged and guess_count unchanged for those 3 cycles; "ba" appears the cycle after stall drops.
REQ-037 reset pulsed while busy=1 -> all outputs 0 in the same cycle (asynchronous); restart produces the first guess again from char_lo.
REQ-038 Illegal configurations -> done=1, cfg_err=1, guess_valid stays 0:
- start_len=0;
- start_len=5, end_len=3;
- char_lo=0x7A, char_hi=0x61.
REQ-039 char_lo=char_hi=0xFF, start_len=14, end_len=15 -> exactly 2 guesses:
- first: guesslen=14, bytes 0..13=0xFF, byte 14=0x00;
- second: guesslen=15, all 15 bytes 0xFF;
- then done=1.

Source files
------------

// File: rtl/md5_guess_generator.sv
// Brute-force candidate enumerator for an MD5 cracking pipeline: walks every
// string over [char_lo..char_hi] for lengths start_len..end_len in odometer order.
module md5_guess_generator #(
    parameter int MAX_LEN = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   start_len,
    input  logic [3:0]   end_len,
    input  logic [7:0]   char_lo,
    input  logic [7:0]   char_hi,
    input  logic         stall,
    output logic [127:0] guess,
    output logic [3:0]   guesslen,
    output logic         guess_valid,
    output logic         busy,
    output logic         done,
    output logic         cfg_err,
    output logic [47:0]  guess_count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] MAX_L = 4'(MAX_LEN);

    state_t       state;
    state_t       state_nxt;
    logic [3:0]   end_len_q;
    logic [7:0]   lo_q;
    logic [7:0]   hi_q;
    logic         accept;
    logic         illegal;
    logic         consume;
    logic         last;
    logic         carry;
    logic [127:0] step_guess;
    logic [3:0]   step_len;

    // Positions 0..len-1 set to ch, the rest zero.
    function automatic logic [127:0] fill(input logic [3:0] len, input logic [7:0] ch);
        logic [127:0] g;
        g = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < int'(len)) g[127-8*i -: 8] = ch;
        end
        return g;
    endfunction

    assign accept  = start && (state != RUN);
    assign illegal = (start_len == 4'd0) || (end_len > MAX_L) ||
                     (start_len > end_len) || (char_lo > char_hi);
    assign consume = (state == RUN) && !stall;

    // Odometer step: ripple a carry from the rightmost active byte leftwards.
    // Comparing against char_hi before incrementing avoids any 0xFF overflow.
    always_comb begin
        step_guess = guess;
        carry      = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            if ((i < int'(guesslen)) && carry) begin
                if (guess[127-8*i -: 8] == hi_q) begin
                    step_guess[127-8*i -: 8] = lo_q;
                end else begin
                    step_guess[127-8*i -: 8] = guess[127-8*i -: 8] + 8'd1;
                    carry = 1'b0;
                end
            end
        end
        step_len = guesslen;
        last     = 1'b0;
        if (carry) begin
            last       = (guesslen == end_len_q);
            step_len   = guesslen + 4'd1;
            step_guess = fill(step_len, lo_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (accept) state_nxt = illegal ? DONE : RUN;
            RUN:        if (consume && last) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state == RUN);
        guess_valid = (state == RUN);
        done        = (state == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            guess       <= '0;
            guesslen    <= '0;
            guess_count <= '0;
            cfg_err     <= 1'b0;
            end_len_q   <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
        end else if (accept) begin
            guess_count <= '0;
            cfg_err     <= illegal;
            end_len_q   <= end_len;
            lo_q        <= char_lo;
            hi_q        <= char_hi;
            if (!illegal) begin
                guess    <= fill(start_len, char_lo);
                guesslen <= start_len;
            end
        end else if (consume) begin
            guess_count <= guess_count + 48'd1;
            if (!last) begin
                guess    <= step_guess;
                guesslen <= step_len;
            end
        end
    end

endmodule

// File: tb/tb_md5_guess_generator.sv
// Randomized bench for md5_guess_generator against a base-N counting model
// of the expected candidate sequence.
module tb_md5_guess_generator;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   start_len;
    logic [3:0]   end_len;
    logic [7:0]   char_lo;
    logic [7:0]   char_hi;
    logic         stall;
    logic [127:0] guess;
    logic [3:0]   guesslen;
    logic         guess_valid;
    logic         busy;
    logic         done;
    logic         cfg_err;
    logic [47:0]  guess_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]   len;
        logic [127:0] g;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    md5_guess_generator #(.MAX_LEN(15)) dut (
        .clk(clk), .reset(reset), .start(start), .start_len(start_len),
        .end_len(end_len), .char_lo(char_lo), .char_hi(char_hi), .stall(stall),
        .guess(guess), .guesslen(guesslen), .guess_valid(guess_valid),
        .busy(busy), .done(done), .cfg_err(cfg_err), .guess_count(guess_count)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Guess number idx of length L is idx written in base n, digit d -> byte lo+d.
    task automatic build(input int sl, input int el, input int lo, input int hi);
        int n;
        int tot;
        int t;
        exp_t e;
        n = hi - lo + 1;
        q.delete();
        for (int L = sl; L <= el; L++) begin
            tot = 1;
            for (int j = 0; j < L; j++) tot = tot * n;
            for (int idx = 0; idx < tot; idx++) begin
                t     = idx;
                e.len = 4'(L);
                e.g   = '0;
                for (int p = L - 1; p >= 0; p--) begin
                    e.g[127-8*p -: 8] = 8'(lo + (t % n));
                    t = t / n;
                end
                q.push_back(e);
            end
        end
    endtask

    // mode 0: never stall; 1: random stall and ignored start pulses;
    // 2: stall three cycles on the fourth guess.
    task automatic run_case(input int sl, input int el, input int lo, input int hi, input int mode);
        int   consumed;
        int   budget;
        int   k;
        int   sc;
        exp_t last_e;
        build(sl, el, lo, hi);
        consumed  = 0;
        k         = 0;
        sc        = 0;
        budget    = 5000;
        last_e    = q[0];
        start     = 1'b1;
        start_len = 4'(sl);
        end_len   = 4'(el);
        char_lo   = 8'(lo);
        char_hi   = 8'(hi);
        @(negedge clk);
        start     = 1'b0;
        start_len = 4'($urandom);
        end_len   = 4'($urandom);
        char_lo   = 8'($urandom);
        char_hi   = 8'($urandom);
        while (q.size() > 0 && budget > 0) begin
            chk("valid", guess_valid, 1'b1);
            chk("busy", busy, 1'b1);
            chk("done_run", done, 1'b0);
            chk("guess", guess, q[0].g);
            chk("len", guesslen, q[0].len);
            chk("count", guess_count, 48'(consumed));
            if (mode == 1) begin
                stall = ($urandom_range(0, 2) == 0);
                start = ($urandom_range(0, 7) == 0);
            end else if (mode == 2 && k == 3 && sc < 3) begin
                stall = 1'b1;
                sc++;
            end else begin
                stall = 1'b0;
            end
            if (!stall) begin
                last_e = q.pop_front();
                consumed++;
                k++;
            end
            @(negedge clk);
            start = 1'b0;
            budget--;
        end
        if (budget == 0) chk("budget", 1'b0, 1'b1);
        stall = 1'b0;
        chk("end_valid", guess_valid, 1'b0);
        chk("end_busy", busy, 1'b0);
        chk("end_done", done, 1'b1);
        chk("end_cfg", cfg_err, 1'b0);
        chk("end_count", guess_count, 48'(consumed));
        chk("end_guess", guess, last_e.g);
        chk("end_len", guesslen, last_e.len);
    endtask

    task automatic illegal_case(input int sl, input int el, input int lo, input int hi);
        start     = 1'b1;
        start_len = 4'(sl);
        end_len   = 4'(el);
        char_lo   = 8'(lo);
        char_hi   = 8'(hi);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("ill_done", done, 1'b1);
            chk("ill_cfg", cfg_err, 1'b1);
            chk("ill_valid", guess_valid, 1'b0);
            chk("ill_busy", busy, 1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int lo;
        int sl;
        int el;
        reset     = 1'b1;
        start     = 1'b0;
        start_len = '0;
        end_len   = '0;
        char_lo   = '0;
        char_hi   = '0;
        stall     = 1'b0;
        @(negedge clk);
        chk("rst_guess", guess, 128'd0);
        chk("rst_len", guesslen, 4'd0);
        chk("rst_valid", guess_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_cfg", cfg_err, 1'b0);
        chk("rst_count", guess_count, 48'd0);
        reset = 1'b0;
        @(negedge clk);

        run_case(1, 1, 8'h61, 8'h63, 0);
        run_case(1, 2, 8'h61, 8'h62, 0);
        run_case(1, 2, 8'h61, 8'h62, 2);
        run_case(14, 15, 8'hFF, 8'hFF, 1);
        run_case(1, 2, 8'hFE, 8'hFF, 1);

        illegal_case(0, 3, 8'h61, 8'h62);
        illegal_case(5, 3, 8'h61, 8'h62);
        illegal_case(1, 2, 8'h7A, 8'h61);
        run_case(2, 2, 8'h30, 8'h32, 1);

        // Asynchronous reset in the middle of a run.
        start     = 1'b1;
        start_len = 4'd2;
        end_len   = 4'd3;
        char_lo   = 8'h61;
        char_hi   = 8'h63;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("arst_guess", guess, 128'd0);
        chk("arst_len", guesslen, 4'd0);
        chk("arst_valid", guess_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_count", guess_count, 48'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", guess_valid, 1'b0);
        run_case(2, 3, 8'h61, 8'h63, 0);

        // Start coincident with reset is ignored.
        reset     = 1'b1;
        start     = 1'b1;
        start_len = 4'd1;
        end_len   = 4'd1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_start_valid", guess_valid, 1'b0);
        chk("rst_start_busy", busy, 1'b0);
        chk("rst_start_done", done, 1'b0);

        for (int r = 0; r < 8; r++) begin
            n  = $urandom_range(1, 3);
            lo = ($urandom_range(0, 3) == 0) ? 256 - n : $urandom_range(0, 250);
            sl = $urandom_range(1, 3);
            el = (n == 1) ? $urandom_range(sl, 15) : $urandom_range(sl, 3);
            run_case(sl, el, lo, lo + n - 1, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
